// File: rtl/vend_pkg.sv
// Shared coin/product encodings, arbiter FSM states and coin valuation for the vending front-end.
package vend_pkg;

  localparam logic [1:0] COIN_ONE     = 2'b00;
  localparam logic [1:0] COIN_TWO     = 2'b01;
  localparam logic [1:0] COIN_FIVE    = 2'b10;
  localparam logic [1:0] COIN_NONE    = 2'b11;

  localparam logic [1:0] PROD_NONE    = 2'b00;
  localparam logic [1:0] PROD_CHOC    = 2'b01;
  localparam logic [1:0] PROD_DRINK   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CHOICE,
    ST_COIN,
    ST_ABORT,
    ST_RESP
  } state_t;

  // Invalid coins are accepted but are worth nothing.
  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_ONE:  return 4'd1;
      COIN_TWO:  return 4'd2;
      COIN_FIVE: return 4'd5;
      default:   return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a simultaneous request goes to the panel not served last.
// Grant is combinational; the last-grant pointer moves only when a session retires.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       any,
  output logic       gnt
);

  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= upd_idx;
    end
  end

  assign any = |req;
  assign gnt = (&req) ? ~last : req[1];

endmodule

// File: rtl/vend_arbiter.sv
// Shares one vending core between two panels: one session at a time, coin handshakes
// forwarded to the core, timeout abort with refund, response held until the panel takes it.
module vend_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] req_choice,
  input  logic [1:0] coin_valid,
  input  logic [3:0] coin_code,
  output logic [1:0] coin_ready,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [1:0] rsp_product,
  output logic [2:0] rsp_change,
  output logic [3:0] rsp_refund,
  output logic       rsp_abort,
  output logic       vm_start,
  output logic       vm_choice,
  output logic       vm_rst,
  output logic [1:0] vm_coins,
  input  logic       vm_done,
  input  logic [1:0] vm_product,
  input  logic [2:0] vm_change,
  output logic       busy
);

  import vend_pkg::*;

  localparam logic [3:0] IDLE_LAST = 4'(TIMEOUT - 1);

  state_t     state;
  logic       grant;
  logic [3:0] credit;
  logic [3:0] idle_cnt;
  logic       arb_any;
  logic       arb_gnt;
  logic       coin_hs;
  logic [1:0] gnt_code;
  logic [1:0] gnt_onehot;
  logic [4:0] credit_sum;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .upd     ((state == ST_RESP) && rsp_ready[grant]),
    .upd_idx (grant),
    .any     (arb_any),
    .gnt     (arb_gnt)
  );

  // A coin is never taken in the cycle the core reports completion.
  assign gnt_code   = grant ? coin_code[3:2] : coin_code[1:0];
  assign gnt_onehot = grant ? 2'b10 : 2'b01;
  assign coin_hs    = (state == ST_COIN) && coin_valid[grant] && !vm_done;
  assign credit_sum = {1'b0, credit} + {1'b0, coin_value(gnt_code)};
  assign coin_ready = coin_hs ? gnt_onehot : 2'b00;
  assign vm_coins   = coin_hs ? gnt_code : COIN_NONE;
  assign vm_rst     = rst || (state == ST_ABORT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= 1'b0;
      vm_choice   <= 1'b0;
      vm_start    <= 1'b0;
      busy        <= 1'b0;
      credit      <= 4'd0;
      idle_cnt    <= 4'd0;
      rsp_valid   <= 2'b00;
      rsp_product <= PROD_NONE;
      rsp_change  <= 3'd0;
      rsp_refund  <= 4'd0;
      rsp_abort   <= 1'b0;
    end else begin
      vm_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            state     <= ST_START;
            grant     <= arb_gnt;
            vm_choice <= req_choice[arb_gnt];
            vm_start  <= 1'b1;
            busy      <= 1'b1;
            credit    <= 4'd0;
          end
        end
        ST_START:  state <= ST_CHOICE;
        ST_CHOICE: begin
          state    <= ST_COIN;
          idle_cnt <= 4'd0;
        end
        ST_COIN: begin
          if (vm_done) begin
            state       <= ST_RESP;
            rsp_valid   <= gnt_onehot;
            rsp_product <= vm_product;
            rsp_change  <= vm_change;
            rsp_refund  <= 4'd0;
            rsp_abort   <= 1'b0;
          end else if (coin_hs) begin
            credit   <= credit_sum[4] ? 4'hF : credit_sum[3:0];
            idle_cnt <= 4'd0;
          end else if (idle_cnt == IDLE_LAST) begin
            state <= ST_ABORT;
          end else begin
            idle_cnt <= idle_cnt + 4'd1;
          end
        end
        ST_ABORT: begin
          state       <= ST_RESP;
          rsp_valid   <= gnt_onehot;
          rsp_product <= PROD_NONE;
          rsp_change  <= 3'd0;
          rsp_refund  <= credit;
          rsp_abort   <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready[grant]) begin
            state     <= ST_IDLE;
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_arbiter.sv
// Randomised and directed sessions against a session-level model of the two-panel vending front-end.
module tb_vend_arbiter;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00, req_choice = 2'b00, coin_valid = 2'b00, rsp_ready = 2'b00;
  logic [3:0] coin_code = 4'd0;
  logic [1:0] coin_ready, rsp_valid, rsp_product, vm_coins;
  logic [2:0] rsp_change;
  logic [3:0] rsp_refund;
  logic       rsp_abort, vm_start, vm_choice, vm_rst, busy;
  logic       vm_done = 1'b0;
  logic [1:0] vm_product = 2'b00;
  logic [2:0] vm_change = 3'd0;

  int checks = 0;
  int errors = 0;
  int exp_last = 1;
  int core_sum = 0;

  always #5 clk = ~clk;

  vend_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_choice(req_choice),
    .coin_valid(coin_valid), .coin_code(coin_code), .coin_ready(coin_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
    .rsp_change(rsp_change), .rsp_refund(rsp_refund), .rsp_abort(rsp_abort),
    .vm_start(vm_start), .vm_choice(vm_choice), .vm_rst(vm_rst), .vm_coins(vm_coins),
    .vm_done(vm_done), .vm_product(vm_product), .vm_change(vm_change), .busy(busy)
  );

  function automatic int coin_val(input logic [1:0] c);
    case (c)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int price_of(input logic choice);
    return choice ? 5 : 2;
  endfunction

  // Round-robin: a lone requester wins; on a tie, the panel not served last wins.
  function automatic int predict(input logic [1:0] rq);
    if (rq == 2'b11) return (exp_last == 0) ? 1 : 0;
    return rq[1] ? 1 : 0;
  endfunction

  // Vending core stand-in: completes one cycle after the credit covers the price.
  always @(posedge clk) begin
    if (vm_rst || vm_start) begin
      core_sum <= 0;
      vm_done  <= 1'b0;
    end else if (core_sum + coin_val(vm_coins) >= price_of(vm_choice)) begin
      core_sum   <= 0;
      vm_done    <= 1'b1;
      vm_product <= vm_choice ? 2'b10 : 2'b01;
      vm_change  <= 3'(core_sum + coin_val(vm_coins) - price_of(vm_choice));
    end else begin
      core_sum <= core_sum + coin_val(vm_coins);
      vm_done  <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic open_session(input string tag, input logic [1:0] rq, input logic [1:0] ch,
                              input logic [1:0] rq_after, output int g);
    g = predict(rq);
    req = rq;
    req_choice = ch;
    #1 chk({tag, "_idle_nostart"}, vm_start, 0);
    @(negedge clk);
    req = rq_after;
    #1;
    chk({tag, "_vm_start"}, vm_start, 1);
    chk({tag, "_vm_choice"}, vm_choice, ch[g]);
    chk({tag, "_busy"}, busy, 1);
  endtask

  // Both panels always offer a coin; only the granted one may be accepted.
  task automatic offer_coin(input string tag, input int g, input logic [1:0] code);
    int k = 0;
    @(negedge clk);
    coin_valid = 2'b11;
    coin_code = 4'($urandom);
    if (g == 1) coin_code[3:2] = code;
    else        coin_code[1:0] = code;
    #1;
    while (coin_ready[g] !== 1'b1 && k < 8) begin
      chk({tag, "_ready_wait"}, coin_ready, 2'b00);
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_coin_ready"}, coin_ready, (g == 1) ? 2'b10 : 2'b01);
    chk({tag, "_vm_coins"}, vm_coins, code);
  endtask

  task automatic session(input string tag, input logic [1:0] rq, input logic [1:0] ch,
                         input logic [1:0] rq_after, input logic [1:0] codes[$], input int hold);
    int g, price, sum, k, first, nrst;
    logic [1:0] oh;
    logic [9:0] exp_pay;
    open_session(tag, rq, ch, rq_after, g);
    oh = (g == 1) ? 2'b10 : 2'b01;
    price = price_of(ch[g]);
    sum = 0;
    foreach (codes[i]) begin
      if (i > 0) repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        coin_valid = 2'b00;
      end
      offer_coin(tag, g, codes[i]);
      sum += coin_val(codes[i]);
      if (sum >= price) break;
    end
    if (sum >= price) begin
      @(negedge clk);
      coin_valid = oh;
      #1;
      chk({tag, "_done_blocks_coin"}, coin_ready, 0);
      chk({tag, "_done_no_coin"}, vm_coins, 2'b11);
      chk({tag, "_rsp_not_early"}, rsp_valid, 0);
      @(negedge clk);
      coin_valid = 2'b00;
      #1;
      exp_pay = {ch[g] ? 2'b10 : 2'b01, 3'(sum - price), 4'd0, 1'b0};
    end else begin
      k = 0;
      first = -1;
      nrst = 0;
      do begin
        @(negedge clk);
        coin_valid = 2'b00;
        #1;
        k++;
        if (vm_rst) begin
          nrst++;
          if (first < 0) first = k;
        end
      end while (rsp_valid == 2'b00 && k < TO + 8);
      chk({tag, "_abort_cycle"}, first, TO + 1);
      chk({tag, "_vm_rst_pulses"}, nrst, 1);
      chk({tag, "_abort_rsp_cycle"}, k, TO + 2);
      exp_pay = {2'b00, 3'b000, 4'(sum), 1'b1};
    end
    chk({tag, "_rsp_valid"}, rsp_valid, oh);
    chk({tag, "_payload"}, {rsp_product, rsp_change, rsp_refund, rsp_abort}, exp_pay);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      rsp_ready = 2'($urandom) & ~oh;
      #1;
      chk({tag, "_hold_valid"}, rsp_valid, oh);
      chk({tag, "_hold_payload"}, {rsp_product, rsp_change, rsp_refund, rsp_abort}, exp_pay);
      chk({tag, "_hold_no_start"}, vm_start, 0);
    end
    @(negedge clk);
    rsp_ready = oh;
    #1 chk({tag, "_accept_valid"}, rsp_valid, oh);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk({tag, "_retired"}, rsp_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    exp_last = g;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cq[$];
    logic [1:0] rq, ch, nxt, cd;
    int g, price, sum, nc;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_coin_ready", coin_ready, 0);
    chk("reset_vm_start", vm_start, 0);
    chk("reset_vm_rst", vm_rst, 1);
    chk("reset_vm_coins", vm_coins, 2'b11);
    chk("reset_payload", {rsp_product, rsp_change, rsp_refund, rsp_abort}, 0);
    rst = 1'b0;
    #1 chk("release_vm_rst", vm_rst, 0);
    repeat (2) begin
      @(negedge clk);
      #1 chk("quiet_busy", busy, 0);
    end

    cq.delete(); cq.push_back(2'b10);
    session("choc_five", 2'b01, 2'b00, 2'b00, cq, 1);

    cq.delete(); cq.push_back(2'b01); cq.push_back(2'b01); cq.push_back(2'b00);
    session("drink_221", 2'b10, 2'b10, 2'b00, cq, 0);

    cq.delete(); cq.push_back(2'b00);
    session("drink_abort", 2'b10, 2'b10, 2'b00, cq, 2);

    open_session("midrst", 2'b10, 2'b10, 2'b00, g);
    offer_coin("midrst", g, 2'b01);
    @(negedge clk);
    coin_valid = 2'b00;
    rst = 1'b1;
    #1 chk("midrst_vm_rst", vm_rst, 1);
    @(negedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_coin_ready", coin_ready, 0);
    chk("midrst_vm_start", vm_start, 0);
    chk("midrst_vm_coins", vm_coins, 2'b11);
    chk("midrst_payload", {rsp_product, rsp_change, rsp_refund, rsp_abort}, 0);
    rst = 1'b0;
    exp_last = 1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("midrst_no_rsp", rsp_valid, 0);
      chk("midrst_idle", busy, 0);
    end

    cq.delete(); cq.push_back(2'b10);
    session("both_first", 2'b11, 2'b01, 2'b11, cq, 0);
    session("both_second", 2'b11, 2'b01, 2'b00, cq, 0);

    session("hold_pending", 2'b01, 2'b00, 2'b10, cq, 5);
    session("pending_served", 2'b10, 2'b10, 2'b00, cq, 0);

    nxt = 2'b00;
    for (int s = 0; s < 24; s++) begin
      rq = (nxt != 2'b00) ? nxt : 2'($urandom_range(1, 3));
      ch = 2'($urandom);
      price = price_of(ch[predict(rq)]);
      cq.delete();
      sum = 0;
      if ($urandom_range(0, 3) == 0) begin
        nc = $urandom_range(1, 3);
        for (int n = 0; n < nc; n++) begin
          cd = 2'($urandom);
          if (sum + coin_val(cd) >= price) cd = 2'b11;
          cq.push_back(cd);
          sum += coin_val(cd);
        end
      end else begin
        while (sum < price) begin
          cd = (cq.size() >= 5) ? 2'b10 : 2'($urandom);
          cq.push_back(cd);
          sum += coin_val(cd);
        end
      end
      nxt = 2'($urandom);
      session("rnd", rq, ch, nxt, cq, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_arbiter.md
VEND_ARBITER -- requirements
Module: vend_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning COIN-state idle cycles before abort (range 2..15).
REQ-002 The block SHALL have port clk, input, 1 bit, system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; reset is synchronous, active-high, on clock clk.
REQ-004 The block SHALL have port req, input, 2 bits, per-panel session request, level.
REQ-005 The block SHALL have port req_choice, input, 2 bits, per-panel selection (0 chocolate, 1 drink), stable while req is high.
REQ-006 The block SHALL have port coin_valid, input, 2 bits, per-panel coin offered.
REQ-007 The block SHALL have port coin_code, input, 4 bits, panel n at [2n+1:2n]; 00 one, 01 two, 10 five, 11 invalid.
REQ-008 The block SHALL have port coin_ready, output, 2 bits, per-panel coin accepted.
REQ-009 The block SHALL have port rsp_valid, output, 2 bits, per-panel response valid.
REQ-010 The block SHALL have port rsp_ready, input, 2 bits, per-panel response taken.
REQ-011 The block SHALL have rsp_product (output, 2), rsp_change (output, 3), rsp_refund (output, 4) and rsp_abort (output, 1), the shared response payload.
REQ-012 The block SHALL have vm_start, vm_choice, vm_rst (outputs, 1) and vm_coins (output, 2), which drive the vending core.
REQ-013 The block SHALL have vm_done (input, 1), vm_product (input, 2) and vm_change (input, 3), the vending core results.
REQ-014 The block SHALL have port busy, output, 1 bit, high when the state is not IDLE.

Function
REQ-015 The block SHALL have the states IDLE, START, CHOICE, COIN, ABORT and RESP.
- IDLE->START: when any req bit is high; the grant is latched.
- START->CHOICE: unconditional.
- CHOICE->COIN: unconditional.
REQ-016 The block SHALL arbitrate round-robin via a last-grant pointer; after reset, panel 0 wins a simultaneous request.
- The pointer updates on leaving RESP.
REQ-017 The block SHALL drive vm_start=1 in START only, and vm_choice=req_choice[grant] latched at grant and held through COIN.
REQ-018 The block SHALL drive vm_coins=11 (no coin) in every state and cycle except a COIN-state coin handshake.
REQ-019 The block SHALL, in COIN, set coin_ready[grant]=coin_valid[grant] & ~vm_done, and hold non-granted coin_ready at 0.
- On handshake, vm_coins = coin_code of the granted panel in that same cycle.
REQ-020 The block SHALL add the coin value (1, 2, 5; invalid 0) to a 4-bit credit register on each handshake, saturating at 15; credit clears on grant.
REQ-021 The block SHALL, in COIN with vm_done=1, capture vm_product and vm_change, set refund=0 and abort=0, and go to RESP.
REQ-022 The block SHALL use a 4-bit idle counter.
- It clears on entry to COIN and on each handshake.
- It increments on each other COIN cycle.
- When it equals TIMEOUT-1 with no handshake and no vm_done, the next state is ABORT.
REQ-023 The block SHALL, in ABORT, drive vm_rst=1 for exactly one cycle, then enter RESP with product=00, change=000, abort=1, refund=credit.
REQ-024 The block SHALL, in RESP, assert rsp_valid[grant] with the payload held stable until rsp_ready[grant]=1, then return to IDLE; no new grant is made while in RESP.
REQ-025 The block SHALL ignore req deassertion mid-session, which completes normally.
REQ-026 The block SHALL meet a latency of one cycle from req high in IDLE to vm_start, and exactly one cycle from vm_done to rsp_valid.

Reset
REQ-027 The block SHALL, while rst=1, reach state IDLE, pointer=1, credit=0, idle counter=0, and all registered payload=0 by the next edge.
REQ-028 The block SHALL drive vm_rst=rst|ABORT combinationally, so a mid-session reset also resets the core in the same cycle.
REQ-029 The block SHALL hold coin_ready, rsp_valid, vm_start and busy at 0 after reset until a new request arrives.

Structure
REQ-030 The shared package vend_pkg SHALL hold the coin codes, product codes (01 chocolate, 10 drink), the state enum, and the coin-value function.
REQ-031 The two-way round-robin arbiter SHALL be the sub-module rr_arb2; all other logic is flat.

Verification
REQ-032 The bench SHALL check: panel0 chocolate, coin five -> rsp_valid[0], product 01, change 011, refund 0, abort 0.
REQ-033 The bench SHALL check: panel1 drink, coins two,two,one -> product 10, change 000; coin_ready[0] stays 0 throughout.
REQ-034 The bench SHALL check: both req high after reset -> panel0 then panel1 served; a second simultaneous request -> panel1 first.
REQ-035 The bench SHALL check: drink, coin one, then no coins for 15 cycles -> one vm_rst pulse, rsp_abort 1, refund 1, product 00.
REQ-036 The bench SHALL check: rst raised in COIN after coin two -> vm_rst high in that cycle, IDLE and outputs 0 next cycle, no rsp_valid.
REQ-037 The bench SHALL check: rsp_ready held low 5 cycles with req[1] pending -> payload stable, no vm_start until acceptance.
